// File: rtl/dm_responder.sv
// ---------------------------------------------------------------------------
// dm_responder
//
// Memory end of the CPU data-memory load/store byte-lane interface. Accepts
// one request at a time. After WAIT_CYCLES wait states it either merges the
// enabled byte lanes of the store data into the addressed word or reads the
// word, then returns the full 32-bit word through a valid/ready handshake.
// Lane extraction and sign/zero extension are left to the requester.
//
// Parameters:
//   ADDR_WIDTH  - word-index bits, depth = 2**ADDR_WIDTH words
//   WAIT_CYCLES - wait states between accept and memory access (0..15)
//   BASE_ADDR   - byte address of word 0 (4-byte aligned)
//
// Ports:
//   clk_i        - clock, rising edge
//   rstn_i       - asynchronous active-low reset
//   req_valid_i  - request present
//   req_ready_o  - responder can accept a request
//   req_we_i     - 1 = store, 0 = load
//   req_addr_i   - byte address, bits [1:0] ignored
//   req_wea_i    - byte-lane write enables
//   req_wdata_i  - lane-aligned store data
//   rsp_valid_o  - response present
//   rsp_ready_i  - requester accepts response
//   rsp_rdata_o  - full word at the addressed location
//   rsp_err_o    - address out of range
// ---------------------------------------------------------------------------
module dm_responder #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [3:0]  req_wea_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int unsigned Depth = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [3:0]            wea_q, wea_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  in_range_q, in_range_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;

   logic [31:0]           mem_q [Depth];
   logic [31:0]           offset;
   logic                  addr_in_range;
   logic [31:0]           mem_rd;
   logic [31:0]           merged;
   logic                  mem_we;

   // Range is decided once at accept time; an offset with any bit at or above
   // ADDR_WIDTH+2 lies past the top word (the shift also covers wide arrays
   // where 4*Depth would not fit in 32 bits).
   always_comb begin
      offset        = req_addr_i - BASE_ADDR;
      addr_in_range = (req_addr_i >= BASE_ADDR) && ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
   end

   // Post-write word: loads leave every lane untouched regardless of wea.
   always_comb begin
      mem_rd = mem_q[idx_q];
      merged = mem_rd;
      for (int i = 0; i < 4; i++) begin
         if (we_q && wea_q[i]) begin
            merged[8*i +: 8] = wdata_q[8*i +: 8];
         end
      end
   end

   assign mem_we = (state_q == StAccess) && we_q && in_range_q;

   // Storage is not reset; only the access cycle writes it.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem_q[idx_q] <= merged;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      idx_d       = idx_q;
      wea_d       = wea_q;
      wdata_d     = wdata_q;
      in_range_d  = in_range_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      req_ready_o = 1'b0;

      unique case (state_q)
         StIdle: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               we_d       = req_we_i;
               idx_d      = offset[ADDR_WIDTH+1:2];
               wea_d      = req_wea_i;
               wdata_d    = req_wdata_i;
               in_range_d = addr_in_range;
               if (WAIT_CYCLES == 0) begin
                  state_d = StAccess;
               end else begin
                  state_d = StWait;
                  cnt_d   = 4'(WAIT_CYCLES);
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StAccess;
            end
         end
         StAccess: begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = ~in_range_q;
            rsp_rdata_d = in_range_q ? merged : 32'd0;
            state_d     = StResp;
         end
         StResp: begin
            // rdata deliberately keeps its value after the handshake.
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               rsp_err_d   = 1'b0;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         we_q        <= 1'b0;
         idx_q       <= '0;
         wea_q       <= 4'd0;
         wdata_q     <= 32'd0;
         in_range_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         idx_q       <= idx_d;
         wea_q       <= wea_d;
         wdata_q     <= wdata_d;
         in_range_q  <= in_range_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule
